// File: rtl/alu_operand_muxes.sv
// Execute-stage operand selection: forwarding muxes for both ALU operands,
// immediate select, destination register select and the EX/MEM-side store-data/dest capture.
module alu_operand_muxes (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegDst,
  input  logic [2:0]  Rt,
  input  logic [2:0]  Rd,
  input  logic        ALUSrc,
  input  logic [1:0]  ForwardA,
  input  logic [1:0]  ForwardB,
  input  logic [15:0] Mem_ALUOut,
  input  logic [15:0] WB_WriteData,
  input  logic [15:0] ReadData1,
  input  logic [15:0] ReadData2,
  input  logic [15:0] Imm,
  input  logic        Stall,
  input  logic        Flush,
  output logic [2:0]  DestReg,
  output logic [15:0] Operand1,
  output logic [15:0] Operand2,
  output logic [15:0] StoreData_q,
  output logic [2:0]  DestReg_q
);

  // Forwarding code 2'b11 is reserved and falls back to the register-file value.
  function automatic logic [15:0] fwd_sel(
    input logic [1:0]  sel,
    input logic [15:0] reg_val,
    input logic [15:0] mem_val,
    input logic [15:0] wb_val
  );
    logic [15:0] res;
    case (sel)
      2'b00:   res = reg_val;
      2'b10:   res = mem_val;
      2'b01:   res = wb_val;
      default: res = reg_val;
    endcase
    return res;
  endfunction

  logic [15:0] w_fwd_a;
  logic [15:0] w_fwd_b;
  logic [15:0] w_operand2;
  logic [2:0]  w_dest_reg;
  logic [15:0] r_store_data;
  logic [2:0]  r_dest_reg;

  // Operand and destination selection; never gated by reset, stall or flush.
  always_comb begin
    w_fwd_a    = fwd_sel(ForwardA, ReadData1, Mem_ALUOut, WB_WriteData);
    w_fwd_b    = fwd_sel(ForwardB, ReadData2, Mem_ALUOut, WB_WriteData);
    w_operand2 = 16'h0000;
    w_dest_reg = 3'b000;
    if (ALUSrc) begin
      w_operand2 = Imm;
    end else begin
      w_operand2 = w_fwd_b;
    end
    if (RegDst) begin
      w_dest_reg = Rd;
    end else begin
      w_dest_reg = Rt;
    end
  end

  // Store data always takes the forwarded B value, even when Operand2 is the immediate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_store_data <= 16'h0000;
      r_dest_reg   <= 3'b000;
    end else if (Flush) begin
      r_store_data <= 16'h0000;
      r_dest_reg   <= 3'b000;
    end else if (Stall) begin
      r_store_data <= r_store_data;
      r_dest_reg   <= r_dest_reg;
    end else begin
      r_store_data <= w_fwd_b;
      r_dest_reg   <= w_dest_reg;
    end
  end

  assign Operand1    = w_fwd_a;
  assign Operand2    = w_operand2;
  assign DestReg     = w_dest_reg;
  assign StoreData_q = r_store_data;
  assign DestReg_q   = r_dest_reg;

endmodule

// File: tb/tb_alu_operand_muxes.sv
// Self-checking bench for alu_operand_muxes: directed vector table, hand sequences for
// stall/flush/reset, and randomized traffic against a source-array reference model.
module tb_alu_operand_muxes;

  logic        clk;
  logic        rst_n;
  logic        RegDst;
  logic [2:0]  Rt;
  logic [2:0]  Rd;
  logic        ALUSrc;
  logic [1:0]  ForwardA;
  logic [1:0]  ForwardB;
  logic [15:0] Mem_ALUOut;
  logic [15:0] WB_WriteData;
  logic [15:0] ReadData1;
  logic [15:0] ReadData2;
  logic [15:0] Imm;
  logic        Stall;
  logic        Flush;
  logic [2:0]  DestReg;
  logic [15:0] Operand1;
  logic [15:0] Operand2;
  logic [15:0] StoreData_q;
  logic [2:0]  DestReg_q;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] exp_sd;
  logic [2:0]  exp_dr;

  alu_operand_muxes dut (
    .clk(clk), .rst_n(rst_n), .RegDst(RegDst), .Rt(Rt), .Rd(Rd), .ALUSrc(ALUSrc),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .Mem_ALUOut(Mem_ALUOut),
    .WB_WriteData(WB_WriteData), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .Imm(Imm), .Stall(Stall), .Flush(Flush), .DestReg(DestReg), .Operand1(Operand1),
    .Operand2(Operand2), .StoreData_q(StoreData_q), .DestReg_q(DestReg_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        regdst;
    logic        alusrc;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [2:0]  e_dest;
    logic [15:0] e_op1;
    logic [15:0] e_op2;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
  endtask

  // Reference: forwarding code indexes a table of candidate sources.
  function automatic logic [15:0] mdl_fwd(input logic [1:0] sel, input logic [15:0] rf,
                                          input logic [15:0] mem, input logic [15:0] wb);
    logic [15:0] src[4];
    src[0] = rf; src[1] = wb; src[2] = mem; src[3] = rf;
    return src[sel];
  endfunction

  task automatic check_comb(input string tag);
    chk({tag, ".Operand1"}, Operand1, mdl_fwd(ForwardA, ReadData1, Mem_ALUOut, WB_WriteData));
    chk({tag, ".Operand2"}, Operand2,
        ALUSrc ? Imm : mdl_fwd(ForwardB, ReadData2, Mem_ALUOut, WB_WriteData));
    chk({tag, ".DestReg"}, {13'd0, DestReg}, {13'd0, RegDst ? Rd : Rt});
  endtask

  // Advance one rising edge with the inputs currently applied, updating the model first.
  task automatic step(input string tag);
    if (Flush) begin
      exp_sd = 16'h0000; exp_dr = 3'b000;
    end else if (!Stall) begin
      exp_sd = mdl_fwd(ForwardB, ReadData2, Mem_ALUOut, WB_WriteData);
      exp_dr = RegDst ? Rd : Rt;
    end
    @(posedge clk);
    #1;
    chk({tag, ".StoreData_q"}, StoreData_q, exp_sd);
    chk({tag, ".DestReg_q"}, {13'd0, DestReg_q}, {13'd0, exp_dr});
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 2'b00, 2'b00, 3'd1, 16'h1111, 16'h2222};
    vecs[1] = '{1'b1, 1'b1, 2'b00, 2'b01, 3'd2, 16'h1111, 16'hFFFF};
    vecs[2] = '{1'b1, 1'b0, 2'b10, 2'b01, 3'd2, 16'hAAAA, 16'hBBBB};
    vecs[3] = '{1'b1, 1'b0, 2'b01, 2'b10, 3'd2, 16'hBBBB, 16'hAAAA};
    vecs[4] = '{1'b1, 1'b0, 2'b11, 2'b11, 3'd2, 16'h1111, 16'h2222};
    vecs[5] = '{1'b0, 1'b1, 2'b11, 2'b10, 3'd1, 16'h1111, 16'hFFFF};

    rst_n = 1'b0; Stall = 1'b0; Flush = 1'b0;
    ReadData1 = 16'h1111; ReadData2 = 16'h2222; Mem_ALUOut = 16'hAAAA;
    WB_WriteData = 16'hBBBB; Imm = 16'hFFFF; Rt = 3'd1; Rd = 3'd2;
    RegDst = 1'b0; ALUSrc = 1'b0; ForwardA = 2'b00; ForwardB = 2'b00;
    #1;
    chk("reset.StoreData_q", StoreData_q, 16'h0000);
    chk("reset.DestReg_q", {13'd0, DestReg_q}, 16'h0000);

    // Combinational paths must track inputs while reset is held.
    for (int i = 0; i < 6; i++) begin
      RegDst = vecs[i].regdst; ALUSrc = vecs[i].alusrc;
      ForwardA = vecs[i].fa; ForwardB = vecs[i].fb;
      #1;
      chk($sformatf("vec%0d.Operand1", i), Operand1, vecs[i].e_op1);
      chk($sformatf("vec%0d.Operand2", i), Operand2, vecs[i].e_op2);
      chk($sformatf("vec%0d.DestReg", i), {13'd0, DestReg}, {13'd0, vecs[i].e_dest});
    end
    @(posedge clk); #1;
    chk("inreset.StoreData_q", StoreData_q, 16'h0000);
    chk("inreset.DestReg_q", {13'd0, DestReg_q}, 16'h0000);

    @(negedge clk);
    rst_n = 1'b1;
    exp_sd = 16'h0000; exp_dr = 3'b000;

    // Load with Imm selected: store data must still be forwarded B.
    RegDst = 1'b1; ALUSrc = 1'b1; ForwardA = 2'b00; ForwardB = 2'b01;
    step("load");
    chk("load.sd_const", StoreData_q, 16'hBBBB);
    chk("load.dr_const", {13'd0, DestReg_q}, 16'h0002);

    Stall = 1'b1; ForwardB = 2'b10; RegDst = 1'b0;
    step("stall1");
    step("stall2");
    chk("stall.sd_const", StoreData_q, 16'hBBBB);

    Flush = 1'b1;
    step("flush_stall");
    chk("flush.sd_const", StoreData_q, 16'h0000);
    Flush = 1'b0; Stall = 1'b0;
    step("reload");

    // Asynchronous reset mid-cycle, away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async.StoreData_q", StoreData_q, 16'h0000);
    chk("async.DestReg_q", {13'd0, DestReg_q}, 16'h0000);
    check_comb("async");
    exp_sd = 16'h0000; exp_dr = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 300; i++) begin
      ReadData1 = 16'($urandom); ReadData2 = 16'($urandom);
      Mem_ALUOut = 16'($urandom); WB_WriteData = 16'($urandom); Imm = 16'($urandom);
      Rt = 3'($urandom); Rd = 3'($urandom);
      RegDst = 1'($urandom); ALUSrc = 1'($urandom);
      ForwardA = 2'($urandom); ForwardB = 2'($urandom);
      Stall = ($urandom_range(0, 3) == 0);
      Flush = ($urandom_range(0, 7) == 0);
      #1;
      check_comb("rand");
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_operand_muxes.md
# alu_operand_muxes

Execute-stage operand selection block for the 16-bit pipelined processor. It resolves data hazards by choosing each ALU operand from the register file, the MEM-stage ALU result or the WB-stage write data. It selects the second operand between the forwarded register value and the immediate, and picks the destination register number. It also captures the store data and the destination register into an EX/MEM-side register.

## Interface
- No parameters; all widths fixed (16-bit data, 3-bit register numbers).
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- RegDst  input  1  destination select: 0 = Rt, 1 = Rd.
- Rt  input  3  rt field of the EX instruction.
- Rd  input  3  rd field of the EX instruction.
- ALUSrc  input  1  Operand2 select: 0 = forwarded B, 1 = Imm.
- ForwardA  input  2  forwarding select for operand A.
- ForwardB  input  2  forwarding select for operand B.
- Mem_ALUOut  input  16  ALU result currently in the MEM stage.
- WB_WriteData  input  16  data being written back in the WB stage.
- ReadData1  input  16  register-file read port 1 (rs).
- ReadData2  input  16  register-file read port 2 (rt).
- Imm  input  16  sign-extended immediate, already extended upstream.
- Stall  input  1  hold the output registers.
- Flush  input  1  clear the output registers (bubble).
- DestReg  output  3  combinational destination register number.
- Operand1  output  16  combinational ALU operand A.
- Operand2  output  16  combinational ALU operand B.
- StoreData_q  output  16  registered forwarded B (store data).
- DestReg_q  output  3  registered DestReg.

## Operation
- Forward mux A (result FwdA) on ForwardA:
  - 00 -> ReadData1.
  - 10 -> Mem_ALUOut.
  - 01 -> WB_WriteData.
  - 11 -> ReadData1 (reserved code, treated as no forwarding).
- Forward mux B (result FwdB): same encoding on ForwardB, with ReadData2 in place of ReadData1.
- Operand1 = FwdA.
- Operand2 = ALUSrc ? Imm : FwdB.
- DestReg = RegDst ? Rd : Rt.
- Store data is always FwdB, never Imm, regardless of ALUSrc.
- Output register update on each rising clk edge:
  - Flush=1 -> StoreData_q=0, DestReg_q=0. Flush has priority over Stall.
  - else Stall=1 -> both registers hold.
  - else StoreData_q<=FwdB, DestReg_q<=DestReg.
- No arithmetic: pure selection, no width conversion.
- Operand1, Operand2 and DestReg are never affected by rst_n, Stall or Flush.

## Timing
- Operand1, Operand2 and DestReg are purely combinational: zero-cycle latency, they follow any input change within the same delta/cycle.
- StoreData_q and DestReg_q have 1-cycle latency: the value selected before edge N appears after edge N.
- Reset: rst_n low immediately forces StoreData_q=0x0000 and DestReg_q=3'b000, independent of clk. The registers stay cleared while rst_n is low. First capture is at the first rising edge after rst_n rises.
- Reset asserted mid-operation discards the captured values. Combinational outputs continue to track their inputs during reset.
- Simultaneous Flush and Stall -> Flush wins.
- No handshake. Inputs are sampled at the rising edge only for the registered path.

## Test plan
Common inputs: ReadData1=0x1111, ReadData2=0x2222, Mem_ALUOut=0xAAAA, WB_WriteData=0xBBBB, Imm=0xFFFF, Rt=1, Rd=2.
- RegDst=0, ALUSrc=0, ForwardA=00, ForwardB=00 -> DestReg=001, Operand1=0x1111, Operand2=0x2222.
- RegDst=1, ALUSrc=1, ForwardB=01 -> DestReg=010, Operand2=0xFFFF. After a clock edge, StoreData_q=0xBBBB and DestReg_q=010.
- ALUSrc=0, ForwardA=10, ForwardB=01 -> Operand1=0xAAAA, Operand2=0xBBBB.
- ForwardA=01, ForwardB=10 -> Operand1=0xBBBB, Operand2=0xAAAA. Then ForwardA=11, ForwardB=11 -> Operand1=0x1111, Operand2=0x2222.
- Registers loaded, then Stall=1 for 2 edges -> StoreData_q and DestReg_q unchanged. Then Flush=1 with Stall=1 -> both 0 after the next edge.
- rst_n pulsed low between clock edges -> StoreData_q=0 and DestReg_q=0 immediately. Operand1 and Operand2 unaffected.
